song_reader: RTL and testbench

- Reader side of the music player's song memory: fetches note entries written by the song loader and plays each one as a square wave on the speaker output.
- Entry format is {duration[DUR_W-1:0], half_period[PERIOD_W-1:0]}.
- Sits between the synchronous song RAM (1-cycle read latency) and the speaker pin.
- Playback is controlled by start and stop pulses from the button logic.

---
 rtl/song_pkg.sv | 28 ++
 rtl/tone_gen.sv | 42 ++++
 rtl/song_reader.sv | 151 +++++++++++++++
 tb/tb_song_reader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// song_pkg: shared definitions for the song reader.
//   - state_t : playback FSM states
//   - HP_LSB / DUR_LSB / dur_lsb() : field positions inside a song entry
//     {duration, half_period}
//   - END_MARKER : duration value that terminates a song
package song_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StPlay,
        StDone
    } state_t;

    localparam int unsigned DEF_PERIOD_W = 12;

    // The half period sits in the low bits and the duration directly above it.
    localparam int unsigned HP_LSB = 0;

    function automatic int unsigned dur_lsb(input int unsigned period_w);
        return period_w;
    endfunction

    localparam int unsigned DUR_LSB    = dur_lsb(DEF_PERIOD_W);
    localparam int unsigned END_MARKER = 0;

endpackage

// File: rtl/tone_gen.sv
// tone_gen: square-wave generator for one note.
//   i_clk          : system clock
//   i_rst          : asynchronous reset, active low
//   i_en           : run enable; counter and output clear while low
//   i_half_period  : half period in clk cycles, 0 means silence
//   o_tone         : square wave, low whenever disabled or resting
module tone_gen #(
    parameter int unsigned PERIOD_W = 12
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic [PERIOD_W-1:0] i_half_period,
    output logic                o_tone
);

    logic [PERIOD_W-1:0] r_cnt;
    logic                r_tone;
    logic [PERIOD_W-1:0] w_hp_last;

    assign w_hp_last = i_half_period - PERIOD_W'(1);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (!i_en || (i_half_period == '0)) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (r_cnt == w_hp_last) begin
            r_cnt  <= '0;
            r_tone <= ~r_tone;
        end else begin
            r_cnt <= r_cnt + PERIOD_W'(1);
        end
    end

    // The toggle on the last enabled cycle would otherwise leak into the
    // first disabled cycle, so the output is masked by the enable.
    assign o_tone = r_tone & i_en;

endmodule

// File: rtl/song_reader.sv
// song_reader: reads note entries from the song RAM and plays them as a
// square wave.
//   i_clk, i_rst   : clock and asynchronous active-low reset
//   i_start        : pulse, starts playback at address 0 when idle
//   i_stop         : pulse, aborts playback
//   o_mem_rd       : read strobe to song RAM (1-cycle read latency)
//   o_mem_addr     : read address
//   i_mem_data     : entry {duration, half_period}, valid the cycle after o_mem_rd
//   o_busy         : high in every state except idle
//   o_done         : one-cycle pulse at end of song or abort
//   o_tone_out     : speaker output
module song_reader
    import song_pkg::*;
#(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned PERIOD_W    = 12,
    parameter int unsigned DUR_W       = 4,
    parameter int unsigned BEAT_CYCLES = 1000
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_stop,
    output logic                      o_mem_rd,
    output logic [ADDR_W-1:0]         o_mem_addr,
    input  logic [DUR_W+PERIOD_W-1:0] i_mem_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_tone_out
);

    localparam int unsigned CYC_W     = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int unsigned DUR_POS   = dur_lsb(PERIOD_W);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BEAT_CYCLES - 1);

    state_t              r_state;
    logic                r_mem_rd;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_busy;
    logic                r_done;
    logic [DUR_W-1:0]    r_dur;
    logic [PERIOD_W-1:0] r_hp;
    logic [DUR_W-1:0]    r_beat_cnt;
    logic [CYC_W-1:0]    r_cyc_cnt;

    logic [DUR_W-1:0]    w_dur_in;
    logic [PERIOD_W-1:0] w_hp_in;
    logic [DUR_W-1:0]    w_dur_last;
    logic                w_note_end;
    logic                w_en;

    assign w_dur_in   = i_mem_data[DUR_POS +: DUR_W];
    assign w_hp_in    = i_mem_data[HP_LSB +: PERIOD_W];
    assign w_dur_last = r_dur - DUR_W'(1);
    assign w_note_end = (r_beat_cnt == w_dur_last) && (r_cyc_cnt == CYC_LAST);
    assign w_en       = (r_state == StPlay);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= StIdle;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dur      <= '0;
            r_hp       <= '0;
            r_beat_cnt <= '0;
            r_cyc_cnt  <= '0;
        end else begin
            // Strobes are high only in the state they are set on entry to.
            r_mem_rd <= 1'b0;
            r_done   <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // Stop wins over a simultaneous start.
                    if (i_start && !i_stop) begin
                        r_state    <= StFetch;
                        r_mem_addr <= '0;
                        r_mem_rd   <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                StFetch: begin
                    if (i_stop) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= StLoad;
                    end
                end
                StLoad: begin
                    r_dur      <= w_dur_in;
                    r_hp       <= w_hp_in;
                    r_beat_cnt <= '0;
                    r_cyc_cnt  <= '0;
                    if (i_stop || (w_dur_in == DUR_W'(END_MARKER))) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= StPlay;
                    end
                end
                StPlay: begin
                    if (i_stop) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else if (w_note_end) begin
                        // The last slot ends the song instead of wrapping to 0.
                        if (r_mem_addr == '1) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= StFetch;
                            r_mem_addr <= r_mem_addr + ADDR_W'(1);
                            r_mem_rd   <= 1'b1;
                        end
                    end else if (r_cyc_cnt == CYC_LAST) begin
                        r_cyc_cnt  <= '0;
                        r_beat_cnt <= r_beat_cnt + DUR_W'(1);
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    tone_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tone_gen (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (w_en),
        .i_half_period (r_hp),
        .o_tone        (o_tone_out)
    );

    assign o_mem_rd   = r_mem_rd;
    assign o_mem_addr = r_mem_addr;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: self-checking bench for song_reader with BEAT_CYCLES = 4.
module tb_song_reader;

    localparam int ADDR_W   = 5;
    localparam int PERIOD_W = 12;
    localparam int DUR_W    = 4;
    localparam int BEAT     = 4;

    logic                      clk;
    logic                      rst;
    logic                      i_start;
    logic                      i_stop;
    logic                      mem_rd;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DUR_W+PERIOD_W-1:0] mem_data;
    logic                      busy;
    logic                      done;
    logic                      tone;

    logic [DUR_W+PERIOD_W-1:0] ram [32];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic              busy;
        logic              done;
        logic              tone;
    } obs_t;

    obs_t exp_q[$];

    // Single-note songs: entry 0 is the note, entry 1 the end marker.
    typedef struct {
        logic [DUR_W-1:0]    dur;
        logic [PERIOD_W-1:0] hp;
        int                  exp_busy;
        int                  exp_high;
        int                  exp_rises;
        int                  exp_reads;
    } vec_t;

    vec_t vecs [8];

    song_reader #(
        .ADDR_W      (ADDR_W),
        .PERIOD_W    (PERIOD_W),
        .DUR_W       (DUR_W),
        .BEAT_CYCLES (BEAT)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .o_mem_rd   (mem_rd),
        .o_mem_addr (mem_addr),
        .i_mem_data (mem_data),
        .o_busy     (busy),
        .o_done     (done),
        .o_tone_out (tone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous song RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic logic [DUR_W+PERIOD_W-1:0] ent(input int d, input int h);
        return {DUR_W'(d), PERIOD_W'(h)};
    endfunction

    task automatic clear_ram();
        for (int i = 0; i < 32; i++) ram[i] = '0;
    endtask

    // Expected cycle-by-cycle outputs for a song played from address 0,
    // starting with the cycle after the start pulse is sampled.
    task automatic build_trace();
        int  addr;
        int  d;
        int  h;
        bit  fin;
        addr = 0;
        fin  = 1'b0;
        while (!fin) begin
            d = int'(ram[addr][PERIOD_W +: DUR_W]);
            h = int'(ram[addr][0 +: PERIOD_W]);
            exp_q.push_back('{1'b1, ADDR_W'(addr), 1'b1, 1'b0, 1'b0});
            exp_q.push_back('{1'b0, ADDR_W'(addr), 1'b1, 1'b0, 1'b0});
            if (d == 0) begin
                fin = 1'b1;
            end else begin
                for (int k = 0; k < d * BEAT; k++) begin
                    logic t;
                    t = (h != 0) ? 1'((k / h) % 2) : 1'b0;
                    exp_q.push_back('{1'b0, ADDR_W'(addr), 1'b1, 1'b0, t});
                end
                if (addr == 31) fin = 1'b1;
                else addr++;
            end
        end
        exp_q.push_back('{1'b0, ADDR_W'(addr), 1'b1, 1'b1, 1'b0});
        exp_q.push_back('{1'b0, ADDR_W'(addr), 1'b0, 1'b0, 1'b0});
    endtask

    // Pulses start, then compares each cycle against the queued trace.
    // poke_idx >= 0 injects an extra start pulse at that trace cycle.
    task automatic run_trace(input string name, input int poke_idx);
        obs_t got;
        obs_t want;
        int   idx;
        idx = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = '{mem_rd, mem_addr, busy, done, tone};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s cycle %0d: got rd=%0b addr=%0d busy=%0b done=%0b tone=%0b, expected rd=%0b addr=%0d busy=%0b done=%0b tone=%0b",
                         name, idx, got.rd, got.addr, got.busy, got.done, got.tone,
                         want.rd, want.addr, want.busy, want.done, want.tone);
            end
            if (idx == poke_idx) i_start = 1'b1;
            tick();
            i_start = 1'b0;
            idx++;
        end
    endtask

    initial begin
        int busy_n;
        int high_n;
        int rise_n;
        int rd_n;
        int done_n;
        int rd_seen;
        int done_seen;
        bit prev;
        bit timed_out;

        vecs[0] = '{4'd1,  12'd2, 9,  2,  1, 2};
        vecs[1] = '{4'd1,  12'd1, 9,  2,  2, 2};
        vecs[2] = '{4'd2,  12'd3, 13, 3,  1, 2};
        vecs[3] = '{4'd2,  12'd0, 13, 0,  0, 2};
        vecs[4] = '{4'd1,  12'd4, 9,  0,  0, 2};
        vecs[5] = '{4'd3,  12'd2, 17, 6,  3, 2};
        vecs[6] = '{4'd15, 12'd7, 65, 28, 4, 2};
        vecs[7] = '{4'd0,  12'd5, 3,  0,  0, 1};

        rst      = 1'b0;
        i_start  = 1'b0;
        i_stop   = 1'b0;
        mem_data = '0;
        clear_ram();
        tick();
        tick();
        check("reset mem_rd", int'(mem_rd), 0);
        check("reset addr", int'(mem_addr), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset tone", int'(tone), 0);
        rst = 1'b1;
        tick();

        // Reset during activity: second note playing, tone high.
        ram[0] = ent(1, 1);
        ram[1] = ent(3, 1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("pre-reset addr", int'(mem_addr), 1);
        check("pre-reset busy", int'(busy), 1);
        check("pre-reset tone", int'(tone), 1);
        rst = 1'b0;
        #1;
        check("async reset addr", int'(mem_addr), 0);
        check("async reset busy", int'(busy), 0);
        check("async reset tone", int'(tone), 0);
        check("async reset done", int'(done), 0);
        rd_seen   = 0;
        done_seen = 0;
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_seen   += int'(mem_rd);
            done_seen += int'(done) + int'(busy);
            tick();
        end
        check("start in reset reads", rd_seen, 0);
        check("start in reset activity", done_seen, 0);
        rst = 1'b1;
        tick();

        // Basic play.
        clear_ram();
        ram[0] = ent(1, 2);
        build_trace();
        run_trace("basic", -1);

        // Rest followed by a fast note.
        ram[0] = ent(2, 0);
        ram[1] = ent(1, 1);
        ram[2] = ent(0, 0);
        build_trace();
        run_trace("rest_multibeat", -1);

        // Single-note vector table.
        foreach (vecs[v]) begin
            clear_ram();
            ram[0] = ent(int'(vecs[v].dur), int'(vecs[v].hp));
            busy_n = 0; high_n = 0; rise_n = 0; rd_n = 0; done_n = 0;
            prev = 1'b0;
            timed_out = 1'b1;
            i_start = 1'b1;
            tick();
            i_start = 1'b0;
            for (int c = 0; c < 200; c++) begin
                busy_n += int'(busy);
                high_n += int'(tone);
                rise_n += int'(tone && !prev);
                rd_n   += int'(mem_rd);
                done_n += int'(done);
                prev = tone;
                if (!busy) begin
                    timed_out = 1'b0;
                    break;
                end
                tick();
            end
            check($sformatf("vec%0d timeout", v), int'(timed_out), 0);
            check($sformatf("vec%0d busy cycles", v), busy_n, vecs[v].exp_busy);
            check($sformatf("vec%0d tone high", v), high_n, vecs[v].exp_high);
            check($sformatf("vec%0d tone rises", v), rise_n, vecs[v].exp_rises);
            check($sformatf("vec%0d reads", v), rd_n, vecs[v].exp_reads);
            check($sformatf("vec%0d done pulses", v), done_n, 1);
        end

        // Stop mid-note at PLAY cycle 5.
        clear_ram();
        ram[0] = ent(3, 3);
        ram[1] = ent(1, 1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("stop pre tone", int'(tone), 1);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check("stop done", int'(done), 1);
        check("stop tone", int'(tone), 0);
        check("stop mem_rd", int'(mem_rd), 0);
        check("stop busy in done", int'(busy), 1);
        rd_seen = 0;
        tick();
        check("stop busy after", int'(busy), 0);
        check("stop done after", int'(done), 0);
        for (int i = 0; i < 6; i++) begin
            rd_seen += int'(mem_rd) + int'(busy);
            tick();
        end
        check("stop no further reads", rd_seen, 0);

        // Full 32-entry song, then a restart.
        for (int i = 0; i < 32; i++) ram[i] = ent(1, 1);
        build_trace();
        run_trace("full_song", -1);
        build_trace();
        run_trace("restart", -1);

        // start + stop together in idle.
        clear_ram();
        ram[0] = ent(1, 1);
        i_start = 1'b1;
        i_stop  = 1'b1;
        tick();
        i_start = 1'b0;
        i_stop  = 1'b0;
        rd_seen = 0;
        for (int i = 0; i < 4; i++) begin
            rd_seen += int'(mem_rd) + int'(busy);
            tick();
        end
        check("start+stop idle", rd_seen, 0);

        // start during PLAY is ignored.
        ram[0] = ent(2, 1);
        ram[1] = ent(1, 3);
        build_trace();
        run_trace("start_in_play", 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
